// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter writing N_REQ requester streams into a single fifo.
// Optional statistics counters are compiled in with macro FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DWIDTH    = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DWIDTH-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          grant_o,
  output logic [DWIDTH-1:0]         fifo_data_o,
  output logic                      fifo_wrreq_o,
  input  logic                      fifo_full_i,
  output logic                      busy_o
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_WIDTH-1:0] stat_word_cnt_o,
  output logic [CNT_WIDTH-1:0]       stat_stall_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255 || CNT_WIDTH < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q;
  logic [PW-1:0]     owner_q;
  logic [PW-1:0]     rr_ptr_q;
  logic [7:0]        beat_cnt_q;

  logic [PW-1:0]     pick_d;
  logic [PW-1:0]     pick_off;
  logic [PW:0]       pick_sum;
  logic              found;
  logic [N_REQ-1:0]  rot_valid;
  logic [PW-1:0]     rr_next;
  logic [DWIDTH-1:0] word [N_REQ];
  logic              busy;
  logic              owner_valid;
  logic              xfer;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then un-rotate.
  always_comb begin
    rot_valid = N_REQ'({req_valid_i, req_valid_i} >> rr_ptr_q);
    pick_off  = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot_valid[i]) begin
        pick_off = PW'(i);
        found    = 1'b1;
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= (PW+1)'(N_REQ)) pick_sum = pick_sum - (PW+1)'(N_REQ);
    pick_d = pick_sum[PW-1:0];
  end

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) word[k] = req_data_i[k*DWIDTH +: DWIDTH];
  end

  assign rr_next     = (owner_q == PW'(N_REQ-1)) ? '0 : owner_q + 1'b1;
  assign busy        = (state_q == BURST);
  assign owner_valid = req_valid_i[owner_q];
  assign xfer        = busy && owner_valid && !fifo_full_i;

  always_comb begin
    grant_o     = '0;
    req_ready_o = '0;
    fifo_data_o = '0;
    if (busy) begin
      grant_o[owner_q]     = 1'b1;
      req_ready_o[owner_q] = !fifo_full_i;
      fifo_data_o          = word[owner_q];
    end
  end

  assign fifo_wrreq_o = xfer;
  assign busy_o       = busy;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            owner_q    <= pick_d;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          // A dropped valid ends the burst even while the fifo is full.
          if (!owner_valid) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_next;
          end else if (!fifo_full_i) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == 8'(MAX_BURST-1)) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] wcnt_q [N_REQ];
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int unsigned k = 0; k < N_REQ; k++) wcnt_q[k] <= '0;
      stall_q <= '0;
    end else begin
      if (xfer && (wcnt_q[owner_q] != '1)) wcnt_q[owner_q] <= wcnt_q[owner_q] + 1'b1;
      if (busy && owner_valid && fifo_full_i && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  always_comb begin
    stat_word_cnt_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) stat_word_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = wcnt_q[k];
  end
  assign stat_stall_cnt_o = stall_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have these parameters: N_REQ, default 4, number of requesters (2..16).
REQ-002 DWIDTH, default 4, data word width; it SHALL match the DWIDTH of the downstream fifo.
REQ-003 MAX_BURST, default 4, maximum words per grant (1..255).
REQ-004 CNT_WIDTH, default 16, width of each statistics counter.
REQ-005 The ports SHALL be as follows:
- clk_i  in  1  single clock; all logic on the rising edge.
- arst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  N_REQ  per-requester word valid.
- req_data_i  in  N_REQ*DWIDTH  requester k's word at bits [k*DWIDTH +: DWIDTH].
- req_ready_o  out  N_REQ  per-requester accept.
- grant_o  out  N_REQ  one-hot current owner; all zero when idle.
- fifo_data_o  out  DWIDTH  to fifo data_i.
- fifo_wrreq_o  out  1  to fifo wrreq_i.
- fifo_full_i  in  1  from fifo full_o.
- busy_o  out  1  high while in BURST.

Function
REQ-006 The FSM SHALL have two states, IDLE and BURST, plus the registers owner, rr_ptr (both $clog2(N_REQ) bits) and beat_cnt (8 bits).
REQ-007 In IDLE with any req_valid_i bit set, the FSM SHALL select the first set bit at or after rr_ptr, searching upward with wrap from N_REQ-1 to 0, load it into owner, clear beat_cnt and enter BURST on the next edge.
REQ-008 No word SHALL transfer in IDLE; arbitration costs exactly one cycle per grant.
REQ-009 In BURST, grant_o SHALL equal the one-hot of owner.
- req_ready_o[owner] SHALL equal !fifo_full_i; all other ready bits SHALL be 0.
- fifo_data_o SHALL equal owner's slice of req_data_i.
- fifo_wrreq_o SHALL equal req_valid_i[owner] && !fifo_full_i.
- All of these outputs are combinational from state and inputs.
REQ-010 A transfer SHALL occur when fifo_wrreq_o is 1; each transfer SHALL increment beat_cnt by 1.
REQ-011 BURST SHALL return to IDLE on the edge after either of these:
- a transfer with beat_cnt == MAX_BURST-1;
- a cycle in which req_valid_i[owner] is 0.
REQ-012 When the FSM leaves BURST, rr_ptr SHALL become owner+1, wrapping to 0 after N_REQ-1.
REQ-013 While fifo_full_i is 1 in BURST, the FSM SHALL stay in BURST, no transfer SHALL occur and beat_cnt SHALL hold.
REQ-014 If fifo_full_i is 1 and req_valid_i[owner] is 0 in the same cycle, the exit to IDLE SHALL take priority.
REQ-015 In IDLE, grant_o, req_ready_o, fifo_wrreq_o, fifo_data_o and busy_o SHALL all be 0.
REQ-016 At most one bit of req_ready_o SHALL be set in any cycle.
REQ-017 fifo_wrreq_o SHALL never be 1 while fifo_full_i is 1.

Reset
REQ-018 While arst_n_i is 0, the block SHALL asynchronously force state=IDLE, owner=0, rr_ptr=0, beat_cnt=0 and, when compiled in, all statistics counters=0.
REQ-019 Through REQ-015, every output SHALL be 0 during reset.
REQ-020 An assertion of arst_n_i during BURST SHALL abort the burst with no further transfer; a word already written to the fifo is not recalled.
REQ-021 After arst_n_i deasserts, the earliest transfer SHALL occur on the second rising edge (one IDLE arbitration cycle, then BURST).

Configuration
REQ-022 With macro FIFO_WR_ARB_STATS_EN defined, the block SHALL add these outputs:
- stat_word_cnt_o, N_REQ*CNT_WIDTH, per-requester transfer counts;
- stat_stall_cnt_o, CNT_WIDTH, cycles in BURST with req_valid_i[owner]=1 and fifo_full_i=1.
Both SHALL be registers that saturate at all-ones.
REQ-023 Without FIFO_WR_ARB_STATS_EN, these ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 The bench SHALL cover these scenarios:
- All 4 requesters continuously valid, MAX_BURST=4, fifo never full -> grants in order 0,1,2,3,0, each 4 transfers followed by 1 idle cycle; 16 words in 20 cycles.
- Only requester 2 valid, holding 10 words -> bursts of 4,4,2, each preceded by one IDLE cycle; rr_ptr returns to 3 after each burst.
- fifo_full_i held high 3 cycles mid-burst after beat 1 -> fifo_wrreq_o=0 and ready[owner]=0 for those 3 cycles, beat_cnt stays 1, and the burst then completes 3 more words.
- Owner drops valid after 2 words while requester 0 is valid -> IDLE the next cycle, then grant moves to the next valid requester after owner.
- arst_n_i pulsed low mid-burst, asynchronously between edges -> all outputs 0 immediately; after release, rr_ptr=0 and requester 0 wins first.
- FIFO_WR_ARB_STATS_EN defined, CNT_WIDTH=4, 20 words from requester 1 -> stat_word_cnt for requester 1 saturates at 15; other counts stay 0.
